music_player_seq: RTL and testbench



---
 rtl/music_player_seq.sv | 178 +++++++++++++++++
 tb/tb_music_player_seq.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/music_player_seq.sv
// Song playback sequencer: steps the ROM beat index, latches each note and drives the buzzer.
// Define MUSIC_LOOP_EN to repeat the song forever instead of returning to idle at the end.
module music_player_seq #(
  parameter int CLK_FREQ    = 50000000,
  parameter int BEAT_CYCLES = 12500000,
  parameter int LAST_BEAT   = 63
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic [4:0] music,
  output logic [5:0] beat_cnt1,
  output logic [4:0] cur_note,
  output logic       buzzer,
  output logic       busy,
  output logic       song_done
);

  // state   | meaning
  // S_IDLE  | silent, waiting for start
  // S_PLAY  | beat timer and tone counter running
  // S_PAUSE | all counters frozen, buzzer forced low, note held
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  localparam logic [31:0] BEAT_LAST = 32'(BEAT_CYCLES - 1);
  localparam logic [5:0]  SONG_LAST = 6'(LAST_BEAT);

  state_t      state_q;
  logic [5:0]  beat_q;
  logic [4:0]  note_q;
  logic [31:0] timer_q;
  logic [23:0] tone_q;
  logic        phase_q;
  logic        buzzer_q;
  logic        busy_q;
  logic        done_q;

  logic [31:0] timer_d;
  logic [23:0] tone_d;
  logic [4:0]  note_d;
  logic        phase_d;
  logic [23:0] hp;
  logic        beat_end;
  logic        song_end;
  logic        capture;
  logic        tone_wrap;

  function automatic logic [23:0] hp_of(input logic [4:0] code);
    case (code)
      5'd1:    hp_of = 24'(CLK_FREQ / (2 * 262));
      5'd2:    hp_of = 24'(CLK_FREQ / (2 * 294));
      5'd3:    hp_of = 24'(CLK_FREQ / (2 * 330));
      5'd4:    hp_of = 24'(CLK_FREQ / (2 * 349));
      5'd5:    hp_of = 24'(CLK_FREQ / (2 * 392));
      5'd6:    hp_of = 24'(CLK_FREQ / (2 * 440));
      5'd7:    hp_of = 24'(CLK_FREQ / (2 * 494));
      5'd8:    hp_of = 24'(CLK_FREQ / (2 * 523));
      5'd9:    hp_of = 24'(CLK_FREQ / (2 * 587));
      5'd10:   hp_of = 24'(CLK_FREQ / (2 * 659));
      5'd11:   hp_of = 24'(CLK_FREQ / (2 * 698));
      5'd12:   hp_of = 24'(CLK_FREQ / (2 * 784));
      5'd13:   hp_of = 24'(CLK_FREQ / (2 * 880));
      5'd14:   hp_of = 24'(CLK_FREQ / (2 * 988));
      5'd15:   hp_of = 24'(CLK_FREQ / (2 * 1047));
      5'd16:   hp_of = 24'(CLK_FREQ / (2 * 1175));
      5'd17:   hp_of = 24'(CLK_FREQ / (2 * 1319));
      5'd18:   hp_of = 24'(CLK_FREQ / (2 * 1397));
      5'd19:   hp_of = 24'(CLK_FREQ / (2 * 1568));
      5'd20:   hp_of = 24'(CLK_FREQ / (2 * 1760));
      5'd21:   hp_of = 24'(CLK_FREQ / (2 * 1976));
      default: hp_of = 24'd0;
    endcase
  endfunction

  // The ROM answers one cycle after the index moves, so the new note is
  // latched when the beat timer reads 1; the tone restarts at phase 0 there.
  always_comb begin
    hp        = hp_of(note_q);
    beat_end  = (timer_q == BEAT_LAST);
    song_end  = beat_end && (beat_q == SONG_LAST);
    capture   = (timer_q == 32'd1);
    tone_wrap = (tone_q == hp - 24'd1);
    timer_d   = beat_end ? 32'd0 : timer_q + 32'd1;
    note_d    = capture ? music : note_q;
    tone_d    = tone_q + 24'd1;
    phase_d   = phase_q;
    if (capture || hp == 24'd0) begin
      tone_d  = 24'd0;
      phase_d = 1'b0;
    end else if (tone_wrap) begin
      tone_d  = 24'd0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      beat_q   <= 6'd0;
      note_q   <= 5'd0;
      timer_q  <= 32'd0;
      tone_q   <= 24'd0;
      phase_q  <= 1'b0;
      buzzer_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        state_q  <= S_PLAY;
        beat_q   <= 6'd0;
        note_q   <= 5'd0;
        timer_q  <= 32'd0;
        tone_q   <= 24'd0;
        phase_q  <= 1'b0;
        buzzer_q <= 1'b0;
        busy_q   <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            buzzer_q <= 1'b0;
            busy_q   <= 1'b0;
          end
          S_PLAY, S_PAUSE: begin
            if (pause) begin
              // phase_q survives the pause so the tone resumes where it stopped
              state_q  <= S_PAUSE;
              buzzer_q <= 1'b0;
            end else if (song_end) begin
              done_q  <= 1'b1;
              beat_q  <= 6'd0;
              timer_q <= 32'd0;
`ifdef MUSIC_LOOP_EN
              state_q  <= S_PLAY;
              note_q   <= note_d;
              tone_q   <= tone_d;
              phase_q  <= phase_d;
              buzzer_q <= phase_d;
`else
              state_q  <= S_IDLE;
              note_q   <= 5'd0;
              tone_q   <= 24'd0;
              phase_q  <= 1'b0;
              buzzer_q <= 1'b0;
              busy_q   <= 1'b0;
`endif
            end else begin
              state_q  <= S_PLAY;
              timer_q  <= timer_d;
              note_q   <= note_d;
              tone_q   <= tone_d;
              phase_q  <= phase_d;
              buzzer_q <= phase_d;
              if (beat_end) begin
                beat_q <= beat_q + 6'd1;
              end
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign beat_cnt1 = beat_q;
  assign cur_note  = note_q;
  assign buzzer    = buzzer_q;
  assign busy      = busy_q;
  assign song_done = done_q;

endmodule

// File: tb/tb_music_player_seq.sv
// Scoreboard bench for music_player_seq: planned output changes are queued per signal
// and a negedge monitor pops and compares every change the DUT makes.
module tb_music_player_seq;

  localparam int CLK_FREQ = 100000;
  localparam int BC       = 400;
  localparam int LAST     = 7;
  localparam int NB       = LAST + 1;
  localparam int BIG      = 32'h7fffffff;
`ifdef MUSIC_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  localparam int SIG_BEAT = 0;
  localparam int SIG_NOTE = 1;
  localparam int SIG_BUZ  = 2;
  localparam int SIG_BUSY = 3;
  localparam int SIG_DONE = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       pause;
  logic [4:0] music = 5'd0;
  logic [5:0] beat_cnt1;
  logic [4:0] cur_note;
  logic       buzzer;
  logic       busy;
  logic       song_done;

  music_player_seq #(
    .CLK_FREQ   (CLK_FREQ),
    .BEAT_CYCLES(BC),
    .LAST_BEAT  (LAST)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pause    (pause),
    .music    (music),
    .beat_cnt1(beat_cnt1),
    .cur_note (cur_note),
    .buzzer   (buzzer),
    .busy     (busy),
    .song_done(song_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [4:0] rom [0:7];
  always @(posedge clk) music <= rom[beat_cnt1[2:0]];

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  ev_t q_beat[$];
  ev_t q_note[$];
  ev_t q_buz[$];
  ev_t q_busy[$];
  ev_t q_done[$];

  int exp_v [5];
  int cut_w = BIG;
  int errors = 0;
  int checks = 0;
  int gen_s, gen_kp, gen_p;
  bit pause_done;
  bit mon_en = 1'b0;

  // Half periods at CLK_FREQ = 100 kHz for the codes used in the song table.
  function automatic int hp_of(input int code);
    case (code)
      1:       return 190;
      8:       return 95;
      13:      return 56;
      21:      return 25;
      default: return 0;
    endcase
  endfunction

  function automatic int wall(input int k);
    return gen_s + k + ((gen_p > 0 && k >= gen_kp) ? gen_p : 0);
  endfunction

  task automatic push(input int sig, input int w, input int v);
    ev_t e;
    if (w >= cut_w || v == exp_v[sig]) return;
    e.cyc = w;
    e.val = v;
    exp_v[sig] = v;
    case (sig)
      SIG_BEAT: q_beat.push_back(e);
      SIG_NOTE: q_note.push_back(e);
      SIG_BUZ:  q_buz.push_back(e);
      SIG_BUSY: q_busy.push_back(e);
      default:  q_done.push_back(e);
    endcase
  endtask

  // Buzzer event at active step k; the first one at/after the pause start also
  // emits the forced-low drop and, if the phase survives, the rise on resume.
  task automatic buz_step(input int k, input bit toggle, input int v);
    int nv;
    nv = toggle ? (exp_v[SIG_BUZ] == 0 ? 1 : 0) : v;
    if (gen_p > 0 && !pause_done && k >= gen_kp) begin
      pause_done = 1'b1;
      if (exp_v[SIG_BUZ] == 1) begin
        push(SIG_BUZ, gen_s + gen_kp, 0);
        if (k > gen_kp) push(SIG_BUZ, gen_s + gen_kp + gen_p, 1);
      end
    end
    push(SIG_BUZ, wall(k), nv);
  endtask

  task automatic plan_song(input int s, input int kp, input int p, input int npass, input bit ends);
    int b, k0, c, n, hp, lim, e, w;
    gen_s = s;
    gen_kp = kp;
    gen_p = p;
    pause_done = 1'b0;
    for (int g = 0; g < npass * NB; g++) begin
      b  = g % NB;
      k0 = g * BC;
      if (g > 0) begin
        push(SIG_BEAT, wall(k0), b);
        if (b == 0) begin
          push(SIG_DONE, wall(k0), 1);
          push(SIG_DONE, wall(k0) + 1, 0);
        end
      end
      c = k0 + 2;
      n = int'(rom[b]);
      buz_step(c, 1'b0, 0);
      push(SIG_NOTE, wall(c), n);
      hp  = hp_of(n);
      lim = (ends && b == LAST) ? k0 + BC : c + BC;
      if (hp > 0) begin
        for (int t = c + hp; t < lim; t += hp) buz_step(t, 1'b1, 0);
      end
    end
    if (ends) begin
      e = npass * NB * BC;
      w = wall(e);
      push(SIG_DONE, w, 1);
      push(SIG_DONE, w + 1, 0);
      push(SIG_BEAT, w, 0);
      push(SIG_NOTE, w, 0);
      buz_step(e, 1'b0, 0);
      push(SIG_BUSY, w, 0);
    end
  endtask

  // start or reset at wall edge w: index, note and buzzer clear
  task automatic abort_at(input int w, input int busy_after);
    cut_w = BIG;
    push(SIG_BEAT, w, 0);
    push(SIG_NOTE, w, 0);
    push(SIG_BUZ, w, 0);
    push(SIG_BUSY, w, busy_after);
  endtask

  task automatic check_ev(input int sig, input string name, input int v);
    ev_t e;
    bit got;
    got = 1'b0;
    case (sig)
      SIG_BEAT: if (q_beat.size() > 0) begin e = q_beat.pop_front(); got = 1'b1; end
      SIG_NOTE: if (q_note.size() > 0) begin e = q_note.pop_front(); got = 1'b1; end
      SIG_BUZ:  if (q_buz.size() > 0)  begin e = q_buz.pop_front();  got = 1'b1; end
      SIG_BUSY: if (q_busy.size() > 0) begin e = q_busy.pop_front(); got = 1'b1; end
      default:  if (q_done.size() > 0) begin e = q_done.pop_front(); got = 1'b1; end
    endcase
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s: changed to %0d at cyc %0d, required no change", name, v, cyc);
    end else if (e.cyc != cyc || e.val != v) begin
      errors++;
      $display("FAIL %s: got %0d at cyc %0d, required %0d at cyc %0d", name, v, cyc, e.val, e.cyc);
    end
  endtask

  task automatic direct_chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  int p_beat, p_note, p_buz, p_busy, p_done;
  always @(negedge clk) begin
    if (mon_en) begin
      if (int'(beat_cnt1) != p_beat) check_ev(SIG_BEAT, "beat_cnt1", int'(beat_cnt1));
      if (int'(cur_note) != p_note)  check_ev(SIG_NOTE, "cur_note", int'(cur_note));
      if (int'(buzzer) != p_buz)     check_ev(SIG_BUZ, "buzzer", int'(buzzer));
      if (int'(busy) != p_busy)      check_ev(SIG_BUSY, "busy", int'(busy));
      if (int'(song_done) != p_done) check_ev(SIG_DONE, "song_done", int'(song_done));
    end
    p_beat = int'(beat_cnt1);
    p_note = int'(cur_note);
    p_buz  = int'(buzzer);
    p_busy = int'(busy);
    p_done = int'(song_done);
  end

  task automatic wait_neg(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  task automatic pulse_start(input int w);
    wait_neg(w - 1);
    start = 1'b1;
    wait_neg(w);
    start = 1'b0;
  endtask

  task automatic pulse_rst(input int w);
    wait_neg(w - 1);
    rst = 1'b0;
    wait_neg(w);
    rst = 1'b1;
  endtask

  int s1, c1, s2, s3, s3b;

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    rom[0] = 5'd13; rom[1] = 5'd21; rom[2] = 5'd1;  rom[3] = 5'd0;
    rom[4] = 5'd8;  rom[5] = 5'd26; rom[6] = 5'd13; rom[7] = 5'd21;
    for (int i = 0; i < 5; i++) exp_v[i] = 0;

    s1  = 10;
    c1  = s1 + 50 + 6500;
    s2  = LOOP ? c1 + 40 : 3300;
    s3  = s2 + 2200;
    s3b = s3 + 2580;

    // run 1: full song with a 50-cycle pause mid-note in beat 1
    abort_at(s1, 1);
    cut_w = LOOP ? c1 : BIG;
    plan_song(s1, 600, 50, LOOP ? 3 : 1, !LOOP);
    if (LOOP) abort_at(c1, 0);
    // run 2: reset during beat 5
    abort_at(s2, 1);
    cut_w = s2 + 2100;
    plan_song(s2, 0, 0, 1, 1'b1);
    abort_at(s2 + 2100, 0);
    // run 3: restart with pause held while beat 6 is sounding
    abort_at(s3, 1);
    cut_w = s3b;
    plan_song(s3, 0, 0, 1, 1'b1);
    abort_at(s3b, 1);
    cut_w = s3b + 920;
    plan_song(s3b, 1, 20, 1, 1'b1);
    abort_at(s3b + 920, 0);

    wait_neg(3);
    rst = 1'b1;
    wait_neg(4);
    direct_chk("reset beat_cnt1", int'(beat_cnt1), 0);
    direct_chk("reset cur_note", int'(cur_note), 0);
    direct_chk("reset buzzer", int'(buzzer), 0);
    direct_chk("reset busy", int'(busy), 0);
    direct_chk("reset song_done", int'(song_done), 0);
    mon_en = 1'b1;

    pulse_start(s1);
    wait_neg(s1 + 600 - 1);
    pause = 1'b1;
    wait_neg(s1 + 650 - 1);
    pause = 1'b0;
    if (LOOP) pulse_rst(c1);

    pulse_start(s2);
    pulse_rst(s2 + 2100);

    pulse_start(s3);
    wait_neg(s3b - 1);
    start = 1'b1;
    pause = 1'b1;
    wait_neg(s3b);
    start = 1'b0;
    wait_neg(s3b + 20);
    pause = 1'b0;
    pulse_rst(s3b + 920);

    wait_neg(s3b + 960);
    direct_chk("leftover beat_cnt1 events", q_beat.size(), 0);
    direct_chk("leftover cur_note events", q_note.size(), 0);
    direct_chk("leftover buzzer events", q_buz.size(), 0);
    direct_chk("leftover busy events", q_busy.size(), 0);
    direct_chk("leftover song_done events", q_done.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
